// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - NCO phase accumulator with sample divider, tuning-word handshake and gated stop.
// Phase advances once per sample tick; stopping waits for the phase to wrap so the output ends at zero.
module phase_accumulator #(
  parameter int ACC_W = 24,
  parameter int DIV   = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] tune_word,
  input  logic             tune_valid,
  output logic             tune_ready,
  input  logic             gate,
  output logic             sample_tick,
  output logic [7:0]       pos_out,
  output logic             busy
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPING
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0] active_q, active_d;
  logic [ACC_W-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [7:0]       pos_q, pos_d;

  logic             tick_w;
  logic [ACC_W-1:0] inc_w;
  logic [ACC_W:0]   sum_w;

  always_comb begin
    tick_w = (cnt_q == CNT_LAST);
    cnt_d  = tick_w ? '0 : cnt_q + CNT_W'(1);

    // A word pending at a tick is promoted and used by that same tick.
    inc_w  = pend_full_q ? pend_q : active_q;
    sum_w  = {1'b0, phase_q} + {1'b0, inc_w};

    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (tick_w && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
    end else if (tune_valid && !pend_full_q) begin
      pend_d      = tune_word;
      pend_full_d = 1'b1;
    end

    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        phase_d = '0;
        if (gate) state_d = S_RUN;
      end
      S_RUN: begin
        if (tick_w) phase_d = sum_w[ACC_W-1:0];
        if (!gate) state_d = S_STOPPING;
      end
      S_STOPPING: begin
        if (gate) begin
          state_d = S_RUN;
          if (tick_w) phase_d = sum_w[ACC_W-1:0];
        end else if (active_q == '0) begin
          state_d = S_IDLE;
          phase_d = '0;
        end else if (tick_w) begin
          if (sum_w[ACC_W]) begin
            state_d = S_IDLE;
            phase_d = '0;
          end else begin
            phase_d = sum_w[ACC_W-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    pos_d = phase_d[ACC_W-1 -: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      phase_q     <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      pos_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      pos_q       <= pos_d;
    end
  end

  assign sample_tick = tick_w;
  assign tune_ready  = !pend_full_q;
  assign pos_out     = pos_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_phase_accumulator.sv
// tb/tb_phase_accumulator.sv - self-checking bench for phase_accumulator (DIV=4, ACC_W=24).
module tb_phase_accumulator;

  localparam int ACC_W = 24;
  localparam int DIV   = 4;
  localparam longint MODV = 64'd1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [ACC_W-1:0] tune_word = '0;
  logic             tune_valid = 1'b0;
  logic             tune_ready;
  logic             gate = 1'b0;
  logic             sample_tick;
  logic [7:0]       pos_out;
  logic             busy;

  int checks = 0;
  int failures = 0;
  bit tick_timeout;

  // Reference: per-sample arithmetic on integers; mode 0 idle, 1 run, 2 stopping.
  int     m_cnt;
  longint m_phase, m_active, m_pend;
  bit     m_has_pend;
  int     m_mode;

  phase_accumulator #(.ACC_W(ACC_W), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .tune_word(tune_word), .tune_valid(tune_valid),
    .tune_ready(tune_ready), .gate(gate), .sample_tick(sample_tick),
    .pos_out(pos_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_cnt = 0; m_phase = 0; m_active = 0; m_pend = 0; m_has_pend = 0; m_mode = 0;
  endtask

  task automatic model_step();
    bit     tick_now, wrapped;
    longint word_used, old_active, next_phase;
    if (!rst_n) begin
      model_clear();
      return;
    end
    tick_now   = (m_cnt == DIV - 1);
    old_active = m_active;
    word_used  = m_active;
    m_cnt      = (m_cnt + 1) % DIV;
    if (tick_now && m_has_pend) begin
      word_used  = m_pend;
      m_active   = m_pend;
      m_has_pend = 0;
    end else if (!m_has_pend && tune_valid) begin
      m_pend     = longint'(tune_word);
      m_has_pend = 1;
    end
    next_phase = m_phase + word_used;
    wrapped    = (next_phase >= MODV);
    next_phase = next_phase % MODV;
    if (m_mode == 0) begin
      m_phase = 0;
      if (gate) m_mode = 1;
    end else if (m_mode == 1) begin
      if (tick_now) m_phase = next_phase;
      if (!gate) m_mode = 2;
    end else begin
      if (gate) begin
        m_mode = 1;
        if (tick_now) m_phase = next_phase;
      end else if (old_active == 0 || (tick_now && wrapped)) begin
        m_mode = 0;
        m_phase = 0;
      end else if (tick_now) begin
        m_phase = next_phase;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic advance_tick();
    bit t;
    for (int i = 0; i < 2 * DIV; i++) begin
      t = sample_tick;
      cycle();
      if (t) return;
    end
    tick_timeout = 1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; tune_valid = 1'b0; tune_word = '0; gate = 1'b0;
    model_clear();
    cycle(); cycle();
    rst_n = 1'b1;
  endtask

  task automatic load_word(input logic [ACC_W-1:0] w);
    tune_word = w; tune_valid = 1'b1;
    cycle();
    tune_valid = 1'b0;
    for (int i = 0; i < 3 * DIV && !tune_ready; i++) cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tune_valid = 1'b1; tune_word = 24'h123456; gate = 1'b1;
    model_clear();
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (sample_tick !== 1'b0 || pos_out !== 8'h00 || busy !== 1'b0 || tune_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold: tick=%b pos=%h busy=%b ready=%b want 0 00 0 1", sample_tick, pos_out, busy, tune_ready);
      end
    end
    tune_valid = 1'b0; gate = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      checks++;
      if (sample_tick !== (i % DIV == 0) || pos_out !== 8'h00 || busy !== 1'b0 || tune_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_release cycle %0d: tick=%b pos=%h busy=%b ready=%b want tick=%b 00 0 1",
                 i, sample_tick, pos_out, busy, tune_ready, (i % DIV == 0));
      end
      cycle();
    end
  endtask

  task automatic test_sweep();
    do_reset();
    load_word(24'h010000);
    gate = 1'b1;
    cycle();
    checks++;
    if (pos_out !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("FAIL sweep_start: pos=%h busy=%b want 00 1", pos_out, busy);
    end
    tick_timeout = 0;
    for (int k = 1; k <= 260; k++) begin
      advance_tick();
      checks++;
      if (pos_out !== 8'(k) || tick_timeout) begin
        failures++;
        $display("FAIL sweep tick %0d: pos=%h want %h timeout=%b", k, pos_out, 8'(k), tick_timeout);
      end
    end
  endtask

  task automatic test_half_stop();
    logic [7:0] want;
    do_reset();
    load_word(24'h800000);
    gate = 1'b1;
    cycle();
    tick_timeout = 0;
    for (int k = 1; k <= 5; k++) begin
      advance_tick();
      want = (k % 2) ? 8'h80 : 8'h00;
      checks++;
      if (pos_out !== want || tick_timeout) begin
        failures++;
        $display("FAIL half_alt tick %0d: pos=%h want %h", k, pos_out, want);
      end
    end
    gate = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b1 || pos_out !== 8'h80) begin
      failures++;
      $display("FAIL half_stopping: busy=%b pos=%h want 1 80", busy, pos_out);
    end
    advance_tick();
    checks++;
    if (pos_out !== 8'h00 || busy !== 1'b0 || tick_timeout) begin
      failures++;
      $display("FAIL half_zero_stop: pos=%h busy=%b want 00 0", pos_out, busy);
    end
  endtask

  task automatic test_tick_capture();
    longint ph;
    do_reset();
    load_word(24'h100000);
    gate = 1'b1;
    cycle();
    tick_timeout = 0;
    advance_tick(); advance_tick();
    ph = 64'h200000;
    for (int i = 0; i < DIV && !sample_tick; i++) cycle();
    tune_word = 24'h030000; tune_valid = 1'b1;
    cycle();
    ph = (ph + 64'h100000) % MODV;
    checks++;
    if (pos_out !== 8'(ph >> 16) || tune_ready !== 1'b0) begin
      failures++;
      $display("FAIL capture_in_tick: pos=%h ready=%b want %h 0", pos_out, tune_ready, 8'(ph >> 16));
    end
    tune_word = 24'h0F0000;
    for (int i = 0; i < DIV - 1; i++) begin
      cycle();
      checks++;
      if (tune_ready !== 1'b0 || sample_tick !== (i == DIV - 2)) begin
        failures++;
        $display("FAIL ready_low %0d: ready=%b tick=%b want 0 %b", i, tune_ready, sample_tick, (i == DIV - 2));
      end
    end
    tune_valid = 1'b0;
    advance_tick();
    ph = (ph + 64'h030000) % MODV;
    checks++;
    if (pos_out !== 8'(ph >> 16) || tune_ready !== 1'b1) begin
      failures++;
      $display("FAIL new_word_applied: pos=%h ready=%b want %h 1", pos_out, tune_ready, 8'(ph >> 16));
    end
    advance_tick();
    ph = (ph + 64'h030000) % MODV;
    checks++;
    if (pos_out !== 8'(ph >> 16) || tick_timeout) begin
      failures++;
      $display("FAIL ignored_offer: pos=%h want %h", pos_out, 8'(ph >> 16));
    end
  endtask

  task automatic test_gate_toggle();
    logic [7:0] want;
    do_reset();
    load_word(24'h100000);
    gate = 1'b1;
    cycle();
    tick_timeout = 0;
    repeat (3) advance_tick();
    for (int k = 4; k <= 7; k++) begin
      gate = (k != 4);
      advance_tick();
      want = 8'(k * 16);
      checks++;
      if (pos_out !== want || busy !== 1'b1 || tick_timeout) begin
        failures++;
        $display("FAIL gate_toggle tick %0d: pos=%h busy=%b want %h 1", k, pos_out, busy, want);
      end
    end
    do_reset();
    gate = 1'b1;
    cycle();
    gate = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_word_stopping: busy=%b want 1", busy);
    end
    cycle();
    checks++;
    if (busy !== 1'b0 || pos_out !== 8'h00) begin
      failures++;
      $display("FAIL zero_word_idle: busy=%b pos=%h want 0 00", busy, pos_out);
    end
  endtask

  task automatic test_reset_stopping();
    do_reset();
    load_word(24'h100000);
    gate = 1'b1;
    cycle();
    tick_timeout = 0;
    advance_tick(); advance_tick();
    gate = 1'b0;
    cycle();
    tune_word = 24'h7F0000; tune_valid = 1'b1;
    cycle();
    tune_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || tune_ready !== 1'b0 || pos_out !== 8'h20) begin
      failures++;
      $display("FAIL pre_reset: busy=%b ready=%b pos=%h want 1 0 20", busy, tune_ready, pos_out);
    end
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (sample_tick !== 1'b0 || pos_out !== 8'h00 || busy !== 1'b0 || tune_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: tick=%b pos=%h busy=%b ready=%b want 0 00 0 1", sample_tick, pos_out, busy, tune_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    gate = 1'b1;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      advance_tick();
      checks++;
      if (pos_out !== 8'h00 || busy !== 1'b1 || tune_ready !== 1'b1 || tick_timeout) begin
        failures++;
        $display("FAIL discarded_pending tick %0d: pos=%h busy=%b ready=%b want 00 1 1", k, pos_out, busy, tune_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e_pos;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_clear();
      end else begin
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) gate = ~gate;
      tune_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: tune_word = '0;
        1: tune_word = 24'h800000;
        2: tune_word = ACC_W'($urandom_range(1, 32'h0FFFFF));
        default: tune_word = ACC_W'($urandom);
      endcase
      cycle();
      e_pos = 8'(m_phase >> (ACC_W - 8));
      checks++;
      if (sample_tick !== (m_cnt == DIV - 1) || pos_out !== e_pos ||
          busy !== (m_mode != 0) || tune_ready !== !m_has_pend) begin
        failures++;
        $display("FAIL random cycle %0d: tick=%b pos=%h busy=%b ready=%b want %b %h %b %b", n,
                 sample_tick, pos_out, busy, tune_ready, (m_cnt == DIV - 1), e_pos, (m_mode != 0), !m_has_pend);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_sweep();
    test_half_stop();
    test_tick_capture();
    test_gate_toggle();
    test_reset_stopping();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
